time_counter: RTL and testbench

Seconds/minutes/hours timekeeper sitting downstream of the 1 s clock divider in the clock exercise. It samples the divider's 1 s square wave (`tick_in`) as data in the `clk` domain, detects each rising edge, and advances a BCD hh:mm:ss count. It also supports run/pause, synchronous clear and validated time-set, and drives BCD digits to the display logic.

---
 rtl/time_counter.sv | 157 +++++++++++++++
 tb/tb_time_counter.sv | 284 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/time_counter.sv
// BCD hh:mm:ss timekeeper advanced once per rising edge of an asynchronous 1 s tick.
// Offers run/pause, synchronous clear and a validated time-set load.
module time_counter #(
    parameter int HOURS = 24
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       tick_in,
    input  logic       run,
    input  logic       clear,
    input  logic       set_en,
    input  logic [7:0] set_h,
    input  logic [7:0] set_m,
    input  logic [7:0] set_s,
    output logic [1:0] hour_t,
    output logic [3:0] hour_o,
    output logic [2:0] min_t,
    output logic [3:0] min_o,
    output logic [2:0] sec_t,
    output logic [3:0] sec_o,
    output logic       sec_pulse,
    output logic       rollover,
    output logic       set_err
);
    localparam logic [1:0] HOUR_LAST_T = 2'((HOURS - 1) / 10);
    localparam logic [3:0] HOUR_LAST_O = 4'((HOURS - 1) % 10);
    localparam logic [7:0] HOUR_MAX    = 8'(HOURS - 1);

    logic       s1;
    logic       s2;
    logic       s3;
    logic [1:0] fill;
    logic       armed;
    logic       rise;

    // A tick held high through reset shows up as a rise in the cycle after the
    // second edge, so the guard stays closed until the third edge.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            s1   <= 1'b0;
            s2   <= 1'b0;
            s3   <= 1'b0;
            fill <= 2'd0;
        end else begin
            s1 <= tick_in;
            s2 <= s1;
            s3 <= s2;
            if (fill != 2'd3) begin
                fill <= fill + 2'd1;
            end
        end
    end

    assign armed = (fill == 2'd3);
    assign rise  = s2 & ~s3 & armed;

    logic [7:0] set_h_val;
    logic       set_ok;

    assign set_h_val = ({4'd0, set_h[7:4]} * 8'd10) + {4'd0, set_h[3:0]};
    assign set_ok    = (set_h[3:0] <= 4'd9) && (set_h_val <= HOUR_MAX) &&
                       (set_m[3:0] <= 4'd9) && (set_m[7:4] <= 4'd5) &&
                       (set_s[3:0] <= 4'd9) && (set_s[7:4] <= 4'd5);

    logic [1:0] n_hour_t;
    logic [3:0] n_hour_o;
    logic [2:0] n_min_t;
    logic [3:0] n_min_o;
    logic [2:0] n_sec_t;
    logic [3:0] n_sec_o;
    logic       n_wrap;

    always_comb begin
        n_hour_t = hour_t;
        n_hour_o = hour_o;
        n_min_t  = min_t;
        n_min_o  = min_o;
        n_sec_t  = sec_t;
        n_sec_o  = sec_o + 4'd1;
        n_wrap   = 1'b0;
        if (sec_o == 4'd9) begin
            n_sec_o = 4'd0;
            if (sec_t != 3'd5) begin
                n_sec_t = sec_t + 3'd1;
            end else begin
                n_sec_t = 3'd0;
                if (min_o != 4'd9) begin
                    n_min_o = min_o + 4'd1;
                end else begin
                    n_min_o = 4'd0;
                    if (min_t != 3'd5) begin
                        n_min_t = min_t + 3'd1;
                    end else begin
                        n_min_t = 3'd0;
                        if ((hour_t == HOUR_LAST_T) && (hour_o == HOUR_LAST_O)) begin
                            n_hour_t = 2'd0;
                            n_hour_o = 4'd0;
                            n_wrap   = 1'b1;
                        end else if (hour_o == 4'd9) begin
                            n_hour_o = 4'd0;
                            n_hour_t = hour_t + 2'd1;
                        end else begin
                            n_hour_o = hour_o + 4'd1;
                        end
                    end
                end
            end
        end
    end

    // clear beats set_en beats a counted rise; the loser is dropped, not deferred.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            hour_t    <= 2'd0;
            hour_o    <= 4'd0;
            min_t     <= 3'd0;
            min_o     <= 4'd0;
            sec_t     <= 3'd0;
            sec_o     <= 4'd0;
            sec_pulse <= 1'b0;
            rollover  <= 1'b0;
            set_err   <= 1'b0;
        end else begin
            sec_pulse <= 1'b0;
            rollover  <= 1'b0;
            set_err   <= 1'b0;
            if (clear) begin
                hour_t <= 2'd0;
                hour_o <= 4'd0;
                min_t  <= 3'd0;
                min_o  <= 4'd0;
                sec_t  <= 3'd0;
                sec_o  <= 4'd0;
            end else if (set_en) begin
                if (set_ok) begin
                    hour_t <= set_h[5:4];
                    hour_o <= set_h[3:0];
                    min_t  <= set_m[6:4];
                    min_o  <= set_m[3:0];
                    sec_t  <= set_s[6:4];
                    sec_o  <= set_s[3:0];
                end else begin
                    set_err <= 1'b1;
                end
            end else if (rise && run) begin
                hour_t    <= n_hour_t;
                hour_o    <= n_hour_o;
                min_t     <= n_min_t;
                min_o     <= n_min_o;
                sec_t     <= n_sec_t;
                sec_o     <= n_sec_o;
                sec_pulse <= 1'b1;
                rollover  <= n_wrap;
            end
        end
    end
endmodule

// File: tb/tb_time_counter.sv
// Bench for time_counter: a 24-hour and a 12-hour instance share stimulus and are
// compared each cycle against a seconds-since-midnight model.
module tb_time_counter;
    logic       clk = 1'b0;
    logic       reset;
    logic       tick_in;
    logic       run;
    logic       clear;
    logic       set_en;
    logic [7:0] set_h;
    logic [7:0] set_m;
    logic [7:0] set_s;

    logic [1:0] a_hour_t, b_hour_t;
    logic [3:0] a_hour_o, b_hour_o;
    logic [2:0] a_min_t, b_min_t;
    logic [3:0] a_min_o, b_min_o;
    logic [2:0] a_sec_t, b_sec_t;
    logic [3:0] a_sec_o, b_sec_o;
    logic       a_sec_pulse, b_sec_pulse;
    logic       a_rollover, b_rollover;
    logic       a_set_err, b_set_err;

    time_counter #(.HOURS(24)) dut24 (
        .clk(clk), .reset(reset), .tick_in(tick_in), .run(run), .clear(clear),
        .set_en(set_en), .set_h(set_h), .set_m(set_m), .set_s(set_s),
        .hour_t(a_hour_t), .hour_o(a_hour_o), .min_t(a_min_t), .min_o(a_min_o),
        .sec_t(a_sec_t), .sec_o(a_sec_o), .sec_pulse(a_sec_pulse),
        .rollover(a_rollover), .set_err(a_set_err)
    );

    time_counter #(.HOURS(12)) dut12 (
        .clk(clk), .reset(reset), .tick_in(tick_in), .run(run), .clear(clear),
        .set_en(set_en), .set_h(set_h), .set_m(set_m), .set_s(set_s),
        .hour_t(b_hour_t), .hour_o(b_hour_o), .min_t(b_min_t), .min_o(b_min_o),
        .sec_t(b_sec_t), .sec_o(b_sec_o), .sec_pulse(b_sec_pulse),
        .rollover(b_rollover), .set_err(b_set_err)
    );

    always #5 clk = ~clk;

    logic [22:0] got24;
    logic [22:0] got12;
    assign got24 = {a_hour_t, a_hour_o, a_min_t, a_min_o, a_sec_t, a_sec_o,
                    a_sec_pulse, a_rollover, a_set_err};
    assign got12 = {b_hour_t, b_hour_o, b_min_t, b_min_o, b_sec_t, b_sec_o,
                    b_sec_pulse, b_rollover, b_set_err};

    int vectors = 0;
    int miscompares = 0;
    int t24 = 0;
    int t12 = 0;

    function automatic logic [22:0] exp_vec(input int secs, input logic p, input logic r,
                                            input logic e);
        int h, m, s;
        h = secs / 3600;
        m = (secs / 60) % 60;
        s = secs % 60;
        return {2'(h / 10), 4'(h % 10), 3'(m / 10), 4'(m % 10), 3'(s / 10), 4'(s % 10),
                p, r, e};
    endfunction

    function automatic bit set_valid(input logic [7:0] h, input logic [7:0] m,
                                     input logic [7:0] s, input int hours);
        int hv;
        hv = int'(h[7:4]) * 10 + int'(h[3:0]);
        return (h[3:0] <= 9) && (m[3:0] <= 9) && (s[3:0] <= 9) &&
               (m[7:4] <= 5) && (s[7:4] <= 5) && (hv < hours);
    endfunction

    function automatic int bcd_secs(input logic [7:0] h, input logic [7:0] m,
                                    input logic [7:0] s);
        return (int'(h[7:4]) * 10 + int'(h[3:0])) * 3600 +
               (int'(m[7:4]) * 10 + int'(m[3:0])) * 60 +
               int'(s[7:4]) * 10 + int'(s[3:0]);
    endfunction

    task automatic check(input string tag, input logic p24, input logic r24, input logic e24,
                         input logic p12, input logic r12, input logic e12);
        logic [22:0] e;
        e = exp_vec(t24, p24, r24, e24);
        vectors++;
        assert (got24 === e) else begin
            miscompares++;
            $error("FAIL %s h24 observed=%h expected=%h", tag, got24, e);
        end
        e = exp_vec(t12, p12, r12, e12);
        vectors++;
        assert (got12 === e) else begin
            miscompares++;
            $error("FAIL %s h12 observed=%h expected=%h", tag, got12, e);
        end
    endtask

    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic idle(input int n, input string tag);
        for (int i = 0; i < n; i++) begin
            step();
            check(tag, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        end
    endtask

    // One tick_in period: high for hi cycles (>=3), then low for lo cycles (>=3).
    task automatic tick(input int hi, input int lo);
        tick_in = 1'b1;
        step();
        check("tick_e1", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        step();
        check("tick_e2", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        step();
        if (run) begin
            t24 = (t24 + 1) % 86400;
            t12 = (t12 + 1) % 43200;
            check("tick_e3", 1'b1, t24 == 0, 1'b0, 1'b1, t12 == 0, 1'b0);
        end else begin
            check("tick_paused", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        end
        idle(hi - 3, "tick_hi");
        tick_in = 1'b0;
        idle(lo, "tick_lo");
    endtask

    task automatic do_set(input logic [7:0] h, input logic [7:0] m, input logic [7:0] s);
        bit ok24, ok12;
        set_h  = h;
        set_m  = m;
        set_s  = s;
        set_en = 1'b1;
        step();
        set_en = 1'b0;
        ok24 = set_valid(h, m, s, 24);
        ok12 = set_valid(h, m, s, 12);
        if (ok24) t24 = bcd_secs(h, m, s);
        if (ok12) t12 = bcd_secs(h, m, s);
        check("set", 1'b0, 1'b0, !ok24, 1'b0, 1'b0, !ok12);
    endtask

    task automatic do_clear();
        clear = 1'b1;
        step();
        clear = 1'b0;
        t24 = 0;
        t12 = 0;
        check("clear", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    initial begin
        reset   = 1'b1;
        tick_in = 1'b0;
        run     = 1'b1;
        clear   = 1'b0;
        set_en  = 1'b0;
        set_h   = 8'h00;
        set_m   = 8'h00;
        set_s   = 8'h00;
        repeat (3) step();
        check("reset", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        reset = 1'b0;
        idle(4, "post_reset");

        // Ten seconds at an 8/8 cadence: ends on 00:00:10.
        for (int i = 0; i < 10; i++) tick(8, 8);

        // Wrap in both modes; 23:59:58 is rejected by the 12-hour instance.
        do_set(8'h23, 8'h59, 8'h58);
        tick(4, 4);
        tick(4, 4);
        do_set(8'h11, 8'h59, 8'h59);
        tick(4, 4);

        // Rejected loads leave the time alone.
        do_set(8'h05, 8'h43, 8'h21);
        do_set(8'h01, 8'h60, 8'h00);
        do_set(8'h24, 8'h00, 8'h00);
        do_set(8'h00, 8'h00, 8'h1A);

        // clear and set_en together, coincident with a rise: clear wins, no count.
        tick_in = 1'b1;
        step();
        check("co_e1", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        step();
        check("co_e2", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        clear  = 1'b1;
        set_en = 1'b1;
        set_h  = 8'h10;
        set_m  = 8'h34;
        set_s  = 8'h56;
        step();
        clear  = 1'b0;
        set_en = 1'b0;
        t24 = 0;
        t12 = 0;
        check("clear_on_rise", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        idle(3, "co_hi");
        tick_in = 1'b0;
        idle(4, "co_lo");

        // set_en alone coincident with a rise: exact load, no increment.
        tick_in = 1'b1;
        step();
        step();
        set_h  = 8'h10;
        set_m  = 8'h20;
        set_s  = 8'h30;
        set_en = 1'b1;
        step();
        set_en = 1'b0;
        t24 = bcd_secs(8'h10, 8'h20, 8'h30);
        t12 = t24;
        check("set_on_rise", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        idle(3, "so_hi");
        tick_in = 1'b0;
        idle(4, "so_lo");

        // Paused rises are lost; resuming while tick_in is high does not count.
        run = 1'b0;
        for (int i = 0; i < 3; i++) tick(5, 5);
        tick_in = 1'b1;
        idle(4, "resume_hi_paused");
        run = 1'b1;
        idle(4, "resume_hi_running");
        tick_in = 1'b0;
        idle(4, "resume_lo");
        tick(5, 5);

        // tick_in high across reset release never counts.
        tick_in = 1'b1;
        reset   = 1'b1;
        t24 = 0;
        t12 = 0;
        step();
        step();
        reset = 1'b0;
        idle(8, "tick_through_reset");
        tick_in = 1'b0;
        idle(4, "ttr_lo");
        tick(4, 4);

        // Reset mid-count clears everything without waiting for an edge.
        do_set(8'h00, 8'h12, 8'h34);
        tick_in = 1'b1;
        step();
        step();
        #1 reset = 1'b1;
        #1;
        t24 = 0;
        t12 = 0;
        check("async_reset", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        @(negedge clk);
        tick_in = 1'b0;
        step();
        reset = 1'b0;
        idle(4, "after_mid_reset");

        // Randomised mix of ticks, loads and clears.
        for (int n = 0; n < 80; n++) begin
            int op;
            op = $urandom_range(0, 9);
            if (op <= 5) begin
                run = ($urandom_range(0, 4) != 0);
                tick($urandom_range(3, 8), $urandom_range(3, 8));
            end else if (op <= 7) begin
                do_set({4'($urandom_range(0, 3)), 4'($urandom_range(0, 10))},
                       {4'($urandom_range(0, 6)), 4'($urandom_range(0, 10))},
                       {4'($urandom_range(0, 6)), 4'($urandom_range(0, 10))});
            end else if (op == 8) begin
                do_set(($urandom_range(0, 1) != 0) ? 8'h23 : 8'h11, 8'h59,
                       {4'h5, 4'($urandom_range(5, 9))});
            end else begin
                do_clear();
            end
        end
        run = 1'b1;
        tick(4, 4);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
